input_conditioner: RTL and testbench

INPUT_CONDITIONER -- requirements
Module: input_conditioner

---
 rtl/input_conditioner.sv | 149 ++++++++++++++
 tb/tb_input_conditioner.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// Push-button conditioner: two-flop synchronizer, per-channel debounce, edge pulses,
// chord detect and optional auto-repeat (compiled in with INPUT_COND_AUTOREPEAT_EN).
module input_conditioner #(
  parameter int NUM_CH          = 4,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_RATE     = 2500000
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic [NUM_CH-1:0] i_Switch,
  output logic [NUM_CH-1:0] o_Level,
  output logic [NUM_CH-1:0] o_Press,
  output logic [NUM_CH-1:0] o_Release,
  output logic [NUM_CH-1:0] o_Step,
  output logic              o_Chord,
  output logic              o_Chord_Pulse
);

  localparam int              DW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0]   DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  if (NUM_CH < 1 || NUM_CH > 16 || DEBOUNCE_CYCLES < 1 ||
      REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_param
    $error("input_conditioner: parameter out of range");
  end

  logic [NUM_CH-1:0] sync_ff1;
  logic [NUM_CH-1:0] sync_ff2;
  logic [DW-1:0]     db_cnt [NUM_CH];
  logic [NUM_CH-1:0] toggle;
  logic [NUM_CH-1:0] level_next;
  logic [NUM_CH-1:0] press_next;
  logic [NUM_CH-1:0] release_next;
  logic              chord_next;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      sync_ff1 <= '0;
      sync_ff2 <= '0;
    end else begin
      sync_ff1 <= i_Switch;
      sync_ff2 <= sync_ff1;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    toggle = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      toggle[c] = (sync_ff2[c] != o_Level[c]) && (db_cnt[c] == DB_LAST);
    end
    level_next   = o_Level ^ toggle;
    press_next   = toggle & ~o_Level;
    release_next = toggle & o_Level;
    chord_next   = &level_next;
  end

  // Edge pulses and chord are registered together with the level they describe.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      // NOTE: the counter array is reset; a stale count could otherwise toggle a level just after reset.
      for (int c = 0; c < NUM_CH; c++) db_cnt[c] <= '0;
      o_Level       <= '0;
      o_Press       <= '0;
      o_Release     <= '0;
      o_Chord       <= 1'b0;
      o_Chord_Pulse <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (sync_ff2[c] == o_Level[c] || toggle[c]) db_cnt[c] <= '0;
        else                                        db_cnt[c] <= db_cnt[c] + 1'b1;
      end
      o_Level       <= level_next;
      o_Press       <= press_next;
      o_Release     <= release_next;
      o_Chord       <= chord_next;
      o_Chord_Pulse <= chord_next & ~o_Chord;
    end
  end

`ifdef INPUT_COND_AUTOREPEAT_EN
  localparam int            RMAX    = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int            RW      = $clog2(RMAX + 1);
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RR_LAST = RW'(REPEAT_RATE - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  logic [1:0]        state   [NUM_CH];
  logic [RW-1:0]     rpt_cnt [NUM_CH];
  logic [NUM_CH-1:0] rpt_step;

  // Chord entry and release both win over a pending step, so a held chord never repeats.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        state[c]   <= ST_IDLE;
        rpt_cnt[c] <= '0;
      end
      rpt_step <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        rpt_step[c] <= 1'b0;
        if (chord_next || release_next[c]) begin
          state[c]   <= ST_IDLE;
          rpt_cnt[c] <= '0;
        end else begin
          case (state[c])
            ST_IDLE: begin
              rpt_cnt[c] <= '0;
              if (press_next[c]) state[c] <= ST_DELAY;
            end
            ST_DELAY: begin
              if (rpt_cnt[c] == RD_LAST) begin
                rpt_step[c] <= 1'b1;
                state[c]    <= ST_REPEAT;
                rpt_cnt[c]  <= '0;
              end else begin
                rpt_cnt[c] <= rpt_cnt[c] + 1'b1;
              end
            end
            ST_REPEAT: begin
              if (rpt_cnt[c] == RR_LAST) begin
                rpt_step[c] <= 1'b1;
                rpt_cnt[c]  <= '0;
              end else begin
                rpt_cnt[c] <= rpt_cnt[c] + 1'b1;
              end
            end
            default: begin
              state[c]   <= ST_IDLE;
              rpt_cnt[c] <= '0;
            end
          endcase
        end
      end
    end
  end

  assign o_Step = (o_Press | rpt_step) & ~{NUM_CH{o_Chord}};
`else
  assign o_Step = o_Press & ~{NUM_CH{o_Chord}};
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner; expectations follow the auto-repeat macro
// INPUT_COND_AUTOREPEAT_EN when it is defined for the build.
module tb_input_conditioner;

`ifdef INPUT_COND_AUTOREPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       i_Clk = 1'b0;
  logic       i_Rst = 1'b1;
  logic [3:0] i_Switch = '0;
  logic [3:0] o_Level, o_Press, o_Release, o_Step;
  logic       o_Chord, o_Chord_Pulse;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 i_Clk = ~i_Clk;

  input_conditioner #(
    .NUM_CH(4), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_RATE(3)
  ) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Switch(i_Switch),
    .o_Level(o_Level), .o_Press(o_Press), .o_Release(o_Release),
    .o_Step(o_Step), .o_Chord(o_Chord), .o_Chord_Pulse(o_Chord_Pulse)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic expect_outs(input string sc, input int t,
                             input logic [3:0] lvl, input logic [3:0] prs,
                             input logic [3:0] rls, input logic [3:0] stp,
                             input logic chd, input logic cp);
    check($sformatf("%s level@%0d", sc, t),   16'(o_Level),       16'(lvl));
    check($sformatf("%s press@%0d", sc, t),   16'(o_Press),       16'(prs));
    check($sformatf("%s release@%0d", sc, t), 16'(o_Release),     16'(rls));
    check($sformatf("%s step@%0d", sc, t),    16'(o_Step),        16'(stp));
    check($sformatf("%s chord@%0d", sc, t),   16'(o_Chord),       16'(chd));
    check($sformatf("%s chordp@%0d", sc, t),  16'(o_Chord_Pulse), 16'(cp));
  endtask

  // Leaves the bench in cycle 0: reset has just been sampled, next edge is the first free one.
  task automatic do_reset(input string sc);
    i_Rst    = 1'b1;
    i_Switch = '0;
    tick();
    tick();
    expect_outs(sc, 0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    i_Rst = 1'b0;
  endtask

  // Step of a channel pressed at cycle 0: press pulse at 6, repeats at 16 then every 3 until release edge.
  function automatic logic step_at(input int t, input int rel);
    return (t == 6) || (AUTO && t >= 16 && t < rel && ((t - 16) % 3) == 0);
  endfunction

  initial begin
    // Single press with auto-repeat, then release; the release edge cancels a coincident step at 25.
    do_reset("press");
    i_Switch[0] = 1'b1;
    for (int t = 1; t <= 40; t++) begin
      tick();
      expect_outs("press", t,
                  {3'b0, (t >= 6 && t < 25)}, {3'b0, t == 6}, {3'b0, t == 25},
                  {3'b0, step_at(t, 25)}, 1'b0, 1'b0);
      if (t == 19) i_Switch[0] = 1'b0;
    end

    // Glitch shorter than the debounce window.
    do_reset("bounce");
    i_Switch[1] = 1'b1;
    for (int t = 1; t <= 15; t++) begin
      tick();
      expect_outs("bounce", t, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
      if (t == 3) i_Switch[1] = 1'b0;
    end

    // All four together: chord entry with presses, steps suppressed.
    do_reset("chord");
    i_Switch = 4'hF;
    for (int t = 1; t <= 24; t++) begin
      tick();
      expect_outs("chord", t, (t >= 6) ? 4'hF : 4'h0, (t == 6) ? 4'hF : 4'h0,
                  4'h0, 4'h0, t >= 6, t == 6);
    end

    // Last channel completes the chord later; chord breaks with ch0..2 still held.
    do_reset("late");
    i_Switch = 4'b0111;
    for (int t = 1; t <= 60; t++) begin
      tick();
      expect_outs("late", t,
                  ((t >= 6) ? 4'b0111 : 4'b0000) | ((t >= 8 && t < 36) ? 4'b1000 : 4'b0000),
                  (t == 6) ? 4'b0111 : ((t == 8) ? 4'b1000 : 4'b0000),
                  (t == 36) ? 4'b1000 : 4'b0000,
                  (t == 6) ? 4'b0111 : 4'b0000,
                  (t >= 8 && t < 36), t == 8);
      if (t == 2)  i_Switch[3] = 1'b1;
      if (t == 30) i_Switch[3] = 1'b0;
    end

    // Reset in the middle of repeating with the button held, then re-debounce.
    do_reset("rst");
    i_Switch[0] = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      tick();
      expect_outs("rst", t, {3'b0, t >= 6}, {3'b0, t == 6}, 4'h0,
                  {3'b0, step_at(t, 1000)}, 1'b0, 1'b0);
    end
    i_Rst = 1'b1;
    tick();
    expect_outs("rst", 21, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    i_Rst = 1'b0;
    for (int t = 22; t <= 32; t++) begin
      tick();
      expect_outs("rst", t, {3'b0, t >= 27}, {3'b0, t == 27}, 4'h0,
                  {3'b0, t == 27}, 1'b0, 1'b0);
    end

    // Long hold on ch2: one step without auto-repeat, press plus repeats with it.
    do_reset("hold");
    i_Switch[2] = 1'b1;
    for (int t = 1; t <= 50; t++) begin
      tick();
      expect_outs("hold", t, {1'b0, t >= 6, 2'b0}, {1'b0, t == 6, 2'b0}, 4'h0,
                  {1'b0, step_at(t, 1000), 2'b0}, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
